// File: rtl/ti_sbox_layer_if.sv
// Stream bundle for the masked S-box layer: two input shares, bypass bit and
// fresh mask on the way in; two refreshed output shares and a beat counter out.
interface ti_sbox_layer_if #(
  parameter int NUM_SBOX = 16,
  parameter int CNT_W    = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_byp;
  logic [4*NUM_SBOX-1:0]   in_s0;
  logic [4*NUM_SBOX-1:0]   in_s1;
  logic [4*NUM_SBOX-1:0]   rnd;
  logic                    out_valid;
  logic                    out_ready;
  logic [4*NUM_SBOX-1:0]   out_s0;
  logic [4*NUM_SBOX-1:0]   out_s1;
  logic [CNT_W-1:0]        out_count;

  modport master (
    output in_valid, in_byp, in_s0, in_s1, rnd, out_ready,
    input  in_ready, out_valid, out_s0, out_s1, out_count
  );

  modport slave (
    input  in_valid, in_byp, in_s0, in_s1, rnd, out_ready,
    output in_ready, out_valid, out_s0, out_s1, out_count
  );
endinterface

// File: rtl/ti_sbox_layer.sv
// Two-share, two-stage threshold implementation of NUM_SBOX Mysterion S-boxes
// with elastic valid/ready flow, per-beat bypass and output mask refresh.

// One lane: cross-share product terms (stage-1 input) and per-domain compression.
// S: x = ab^c, y = b^ab^ac^ad^abc, z = b^c^d^bc, t = a^cd^abd.
module ti_sbox_lane (
  input  logic [3:0]      s0_i,
  input  logic [3:0]      s1_i,
  input  logic [4:0][3:0] q2_i,
  input  logic [1:0][7:0] q3_i,
  input  logic [3:0]      r0_i,
  input  logic [3:0]      r1_i,
  output logic [4:0][3:0] q2_o,
  output logic [1:0][7:0] q3_o,
  output logic [3:0]      c0_o,
  output logic [3:0]      c1_o
);
  // Term index bit k selects the share of the k-th variable; the domain of a
  // term is the share index of its first variable.
  function automatic logic [3:0] x2(input logic [1:0] u, input logic [1:0] v);
    return {u[1] & v[1], u[0] & v[1], u[1] & v[0], u[0] & v[0]};
  endfunction

  function automatic logic [7:0] x3(input logic [1:0] u, input logic [1:0] v,
                                    input logic [1:0] w);
    return {u[1] & v[1] & w[1], u[0] & v[1] & w[1], u[1] & v[0] & w[1], u[0] & v[0] & w[1],
            u[1] & v[1] & w[0], u[0] & v[1] & w[0], u[1] & v[0] & w[0], u[0] & v[0] & w[0]};
  endfunction

  function automatic logic f2(input logic [3:0] t, input logic dom);
    return dom ? (t[1] ^ t[3]) : (t[0] ^ t[2]);
  endfunction

  function automatic logic f3(input logic [7:0] t, input logic dom);
    return dom ? (t[1] ^ t[3] ^ t[5] ^ t[7]) : (t[0] ^ t[2] ^ t[4] ^ t[6]);
  endfunction

  function automatic logic [3:0] comp(input logic [4:0][3:0] q2, input logic [1:0][7:0] q3,
                                      input logic [3:0] r, input logic dom);
    logic x, y, z, t;
    x = f2(q2[0], dom) ^ r[2];
    y = r[1] ^ f2(q2[0], dom) ^ f2(q2[1], dom) ^ f2(q2[2], dom) ^ f3(q3[0], dom);
    z = r[1] ^ r[2] ^ r[3] ^ f2(q2[3], dom);
    t = r[0] ^ f2(q2[4], dom) ^ f3(q3[1], dom);
    return {t, z, y, x};
  endfunction

  logic [1:0] a, b, c, d;
  assign a = {s1_i[0], s0_i[0]};
  assign b = {s1_i[1], s0_i[1]};
  assign c = {s1_i[2], s0_i[2]};
  assign d = {s1_i[3], s0_i[3]};

  assign q2_o[0] = x2(a, b);
  assign q2_o[1] = x2(a, c);
  assign q2_o[2] = x2(a, d);
  assign q2_o[3] = x2(b, c);
  assign q2_o[4] = x2(c, d);
  assign q3_o[0] = x3(a, b, c);
  assign q3_o[1] = x3(a, b, d);

  assign c0_o = comp(q2_i, q3_i, r0_i, 1'b0);
  assign c1_o = comp(q2_i, q3_i, r1_i, 1'b1);
endmodule

module ti_sbox_layer #(
  parameter int NUM_SBOX = 16,
  parameter int CNT_W    = 16
) (
  input logic            clk,
  input logic            rst,
  ti_sbox_layer_if.slave bus
);
  typedef logic [NUM_SBOX-1:0][3:0] nib_t;

  logic v1_q, v1_d, v2_q, v2_d, byp1_q;
  logic accept, adv2;
  nib_t s0_n, s1_n, s0_1_q, s1_1_q, comp0, comp1;
  nib_t out0_q, out0_d, out1_q, out1_d;
  logic [NUM_SBOX-1:0][4:0][3:0] q2_q, q2_d;
  logic [NUM_SBOX-1:0][1:0][7:0] q3_q, q3_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign s0_n = nib_t'(bus.in_s0);
  assign s1_n = nib_t'(bus.in_s1);

  assign adv2          = v1_q & (~v2_q | bus.out_ready);
  assign bus.in_ready  = ~v1_q | adv2;
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out_valid = v2_q;
  assign bus.out_s0    = out0_q;
  assign bus.out_s1    = out1_q;
  assign bus.out_count = cnt_q;

  for (genvar i = 0; i < NUM_SBOX; i++) begin : g_lane
    ti_sbox_lane u_lane (
      .s0_i (s0_n[i]),
      .s1_i (s1_n[i]),
      .q2_i (q2_q[i]),
      .q3_i (q3_q[i]),
      .r0_i (s0_1_q[i]),
      .r1_i (s1_1_q[i]),
      .q2_o (q2_d[i]),
      .q3_o (q3_d[i]),
      .c0_o (comp0[i]),
      .c1_o (comp1[i])
    );
  end

  always_comb begin
    v1_d   = accept | (v1_q & ~adv2);
    v2_d   = adv2 | (v2_q & ~bus.out_ready);
    cnt_d  = cnt_q + CNT_W'(v2_q & bus.out_ready);
    // The same fresh mask lands on both shares, so it cancels on recombination.
    out0_d = byp1_q ? s0_1_q : (comp0 ^ nib_t'(bus.rnd));
    out1_d = byp1_q ? s1_1_q : (comp1 ^ nib_t'(bus.rnd));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      byp1_q <= 1'b0;
      s0_1_q <= '0;
      s1_1_q <= '0;
      q2_q   <= '0;
      q3_q   <= '0;
      out0_q <= '0;
      out1_q <= '0;
      cnt_q  <= '0;
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      cnt_q <= cnt_d;
      if (accept) begin
        byp1_q <= bus.in_byp;
        s0_1_q <= s0_n;
        s1_1_q <= s1_n;
        q2_q   <= q2_d;
        q3_q   <= q3_d;
      end
      if (adv2) begin
        out0_q <= out0_d;
        out1_q <= out1_d;
      end
    end
  end
endmodule

// File: tb/tb_ti_sbox_layer.sv
// Directed + randomized bench for ti_sbox_layer against a table-based S-box model.
module tb_ti_sbox_layer;
  localparam int NS = 16;
  localparam int CW = 4;
  localparam int W  = 4 * NS;
  localparam logic [3:0] SBOX [16] = '{4'h0, 4'h8, 4'h6, 4'hD, 4'h5, 4'hF, 4'h7, 4'hC,
                                       4'h4, 4'hE, 4'h2, 4'h3, 4'h9, 4'h1, 4'hB, 4'hA};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ti_sbox_layer_if #(.NUM_SBOX(NS), .CNT_W(CW)) bif ();
  ti_sbox_layer #(.NUM_SBOX(NS), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bif));

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  logic [W-1:0] qs0 [16];
  logic [W-1:0] qs1 [16];
  logic         qb  [16];

  function automatic logic [W-1:0] ref_layer(input logic [W-1:0] u);
    logic [W-1:0] r;
    for (int i = 0; i < NS; i++) r[4*i +: 4] = SBOX[u[4*i +: 4]];
    return r;
  endfunction

  function automatic logic [W-1:0] rand_w();
    return {$urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  // Single beat with out_ready high; lat counts clock edges from accept to out_valid.
  task automatic beat(input logic [W-1:0] s0, input logic [W-1:0] s1, input logic [W-1:0] r,
                      input logic byp, output logic [W-1:0] o0, output logic [W-1:0] o1,
                      output int lat);
    int n;
    @(negedge clk);
    bif.in_valid = 1'b1; bif.in_s0 = s0; bif.in_s1 = s1; bif.in_byp = byp;
    bif.rnd = r; bif.out_ready = 1'b1;
    n = 0;
    #1;
    while (!bif.in_ready && n < 20) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    bif.in_valid = 1'b0;
    n = 1;
    while (!bif.out_valid && n < 20) begin @(negedge clk); n++; end
    lat = n;
    if (bif.out_valid) begin
      o0 = bif.out_s0; o1 = bif.out_s1; exp_cnt++;
    end else begin
      o0 = 'x; o1 = 'x;
    end
  endtask

  // Streams qs0/qs1/qb[0..n-1]; out_ready is low during cycles st_lo..st_hi.
  task automatic stream(input int n, input int st_lo, input int st_hi, input string tag);
    int sent, got;
    logic prev_stall;
    logic [W-1:0] p0, p1;
    sent = 0; got = 0; prev_stall = 1'b0; p0 = '0; p1 = '0;
    for (int c = 0; c < 200 && got < n; c++) begin
      @(negedge clk);
      bif.out_ready = !(c >= st_lo && c <= st_hi);
      bif.in_valid  = (sent < n);
      if (sent < n) begin
        bif.in_s0 = qs0[sent]; bif.in_s1 = qs1[sent]; bif.in_byp = qb[sent];
      end
      bif.rnd = rand_w();
      #1;
      if (prev_stall) begin
        chk({tag, "_stall_valid"}, bif.out_valid, 1);
        chk({tag, "_stall_s0"}, bif.out_s0, p0);
        chk({tag, "_stall_s1"}, bif.out_s1, p1);
      end
      if (sent - got == 2 && !bif.out_ready) chk({tag, "_full_ready"}, bif.in_ready, 0);
      if (bif.out_valid && bif.out_ready) begin
        if (qb[got]) begin
          chk({tag, "_byp_s0"}, bif.out_s0, qs0[got]);
          chk({tag, "_byp_s1"}, bif.out_s1, qs1[got]);
        end else begin
          chk({tag, "_sbox"}, bif.out_s0 ^ bif.out_s1, ref_layer(qs0[got] ^ qs1[got]));
        end
        got++;
        exp_cnt++;
      end
      prev_stall = bif.out_valid && !bif.out_ready;
      p0 = bif.out_s0; p1 = bif.out_s1;
      if (bif.in_valid && bif.in_ready) sent++;
    end
    bif.in_valid = 1'b0;
    bif.out_ready = 1'b1;
    chk({tag, "_beats_out"}, got, n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] u, m, m2, o0, o1, a0, a1, r;
    logic [3:0] cnt_now;
    int lat;
    logic seen;
    bif.in_valid = 1'b0; bif.in_byp = 1'b0; bif.in_s0 = '0; bif.in_s1 = '0;
    bif.rnd = '0; bif.out_ready = 1'b1;

    // 1. reset state and a single all-zero-unshared beat
    repeat (2) @(negedge clk);
    chk("rst_out_valid", bif.out_valid, 0);
    chk("rst_out_s0", bif.out_s0, 0);
    chk("rst_out_s1", bif.out_s1, 0);
    chk("rst_out_count", bif.out_count, 0);
    rst = 1'b0;
    #1 chk("rst_in_ready", bif.in_ready, 1);
    beat(64'hA5A5_5A5A_0F0F_F0F0, 64'hA5A5_5A5A_0F0F_F0F0, '0, 1'b0, o0, o1, lat);
    chk("t1_latency", lat, 2);
    chk("t1_recomb", o0 ^ o1, 0);
    @(negedge clk);
    chk("t1_count", bif.out_count, 1);

    // 2. lane-0 boolean spot checks, then full table under random masks
    u = '0; u[3:0] = 4'h3; m = rand_w();
    beat(u ^ m, m, rand_w(), 1'b0, o0, o1, lat); r = o0 ^ o1;
    chk("t2_x_of_3", r[0], 1);
    u = '0; u[3:0] = 4'h4; m = rand_w();
    beat(u ^ m, m, rand_w(), 1'b0, o0, o1, lat); r = o0 ^ o1;
    chk("t2_x_of_4", r[0], 1);
    u = '0; u[3:0] = 4'h7; m = rand_w();
    beat(u ^ m, m, rand_w(), 1'b0, o0, o1, lat); r = o0 ^ o1;
    chk("t2_x_of_7", r[0], 0);
    u = '0; m = rand_w();
    beat(u ^ m, m, rand_w(), 1'b0, o0, o1, lat);
    chk("t2_zero", o0 ^ o1, 0);
    for (int nib = 0; nib < 16; nib++) begin
      for (int k = 0; k < 8; k++) begin
        u = rand_w(); u[3:0] = 4'(nib); m = rand_w();
        beat(u ^ m, m, rand_w(), 1'b0, o0, o1, lat);
        chk("t2_table", o0 ^ o1, ref_layer(u));
      end
    end

    // 3. mask independence and refresh
    u = rand_w(); m = rand_w(); m2 = rand_w();
    beat(u ^ m, m, rand_w(), 1'b0, o0, o1, lat);
    chk("t3_mask_a", o0 ^ o1, ref_layer(u));
    beat(u ^ m2, m2, rand_w(), 1'b0, o0, o1, lat);
    chk("t3_mask_b", o0 ^ o1, ref_layer(u));
    beat(u ^ m, m, '0, 1'b0, a0, a1, lat);
    beat(u ^ m, m, '1, 1'b0, o0, o1, lat);
    chk("t3_flip_s0", a0 ^ o0, '1);
    chk("t3_flip_s1", a1 ^ o1, '1);
    chk("t3_flip_recomb", o0 ^ o1, ref_layer(u));

    // 4. backpressure: 5 beats, out_ready low for cycles 2..6
    do_reset();
    for (int i = 0; i < 5; i++) begin qs1[i] = rand_w(); qs0[i] = rand_w(); qb[i] = 1'b0; end
    stream(5, 2, 6, "t4");
    @(negedge clk);
    chk("t4_count", bif.out_count, 5);

    // 5. bypass interleave 1,0,1 back to back
    for (int i = 0; i < 3; i++) begin qs1[i] = rand_w(); qs0[i] = rand_w(); qb[i] = (i != 1); end
    stream(3, 1000, 0, "t5");

    // 6. reset with two beats in flight, then counter wrap
    @(negedge clk);
    bif.out_ready = 1'b0; bif.in_valid = 1'b1; bif.in_byp = 1'b0;
    bif.in_s0 = rand_w(); bif.in_s1 = rand_w();
    @(negedge clk);
    bif.in_s0 = rand_w(); bif.in_s1 = rand_w();
    @(negedge clk);
    bif.in_valid = 1'b0;
    #1 chk("t6_inflight_valid", bif.out_valid, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", bif.out_valid, 0);
    chk("t6_rst_count", bif.out_count, 0);
    chk("t6_rst_ready", bif.in_ready, 1);
    @(negedge clk);
    rst = 1'b0; exp_cnt = 0; bif.out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (bif.out_valid) seen = 1'b1; end
    chk("t6_no_stale", seen, 0);
    u = rand_w(); m = rand_w();
    beat(u ^ m, m, rand_w(), 1'b0, o0, o1, lat);
    chk("t6_first_after_rst", o0 ^ o1, ref_layer(u));
    for (int i = 0; i < 16; i++) begin
      qs1[i] = rand_w(); qs0[i] = rand_w(); qb[i] = 1'($urandom_range(0, 1));
    end
    stream(16, 1000, 0, "t6");
    @(negedge clk);
    cnt_now = exp_cnt[3:0];
    chk("t6_wrap_model", bif.out_count, cnt_now);
    chk("t6_wrap_17", bif.out_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
